fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for a FIFO built around an
// external dual-port RAM with one-cycle registered read data. The RAM
// is clocked by clk on both ports; this block only steers addresses,
// write enable and data, and qualifies the returned read word.
module fifo_ctrl #(
   parameter int ADDR_BITS   = 8,
   parameter int WORD_LENGTH = 8,
   parameter int AFULL_LEVEL = 2**ADDR_BITS - 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   // push side
   input  logic                   wr_en,
   input  logic [WORD_LENGTH-1:0] wr_data,
   // pop side
   input  logic                   rd_en,
   output logic [WORD_LENGTH-1:0] rd_data,
   output logic                   rd_valid,
   // status
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic [ADDR_BITS:0]     count,
   output logic                   overflow,
   output logic                   underflow,
   // RAM write port
   output logic                   ram_w_en,
   output logic [ADDR_BITS-1:0]   ram_w_addr,
   output logic [WORD_LENGTH-1:0] ram_w_data,
   // RAM read port
   output logic [ADDR_BITS-1:0]   ram_r_addr,
   input  logic [WORD_LENGTH-1:0] ram_r_data
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the RAM address bits coincide.
   localparam int              PTR_W     = ADDR_BITS + 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0] AFULL_CMP = PTR_W'(AFULL_LEVEL);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count_q, count_d;
   logic             rd_valid_q, rd_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             full_w;
   logic             empty_w;
   logic             almost_full_w;
   logic             push_acc;
   logic             pop_acc;

   // Status flags decoded only from registered state, never from requests.
   always_comb begin
      empty_w       = (wr_ptr_q == rd_ptr_q);
      full_w        = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
                      (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);
      almost_full_w = (count_q >= AFULL_CMP);
   end

   // Accept decisions; rst_n gates them so no RAM write leaks out while
   // the controller is held in reset.
   always_comb begin
      push_acc = wr_en & ~full_w  & rst_n;
      pop_acc  = rd_en & ~empty_w & rst_n;
   end

   // Next-state for pointers, occupancy, read-valid and sticky error flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_valid_d  = pop_acc;
      overflow_d  = overflow_q  | (wr_en & full_w);
      underflow_d = underflow_q | (rd_en & empty_w);

      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // Simultaneous push and pop leave occupancy unchanged.
      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   // State register with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Output mapping: RAM port steering and status.
   always_comb begin
      ram_w_en    = push_acc;
      ram_w_addr  = wr_ptr_q[ADDR_BITS-1:0];
      ram_w_data  = wr_data;
      ram_r_addr  = rd_ptr_q[ADDR_BITS-1:0];
      rd_data     = ram_r_data;
      rd_valid    = rd_valid_q;
      full        = full_w;
      empty       = empty_w;
      almost_full = almost_full_w;
      count       = count_q;
      overflow    = overflow_q;
      underflow   = underflow_q;
   end

endmodule
